// File: rtl/sign_magnitude_pipe.sv
// Two-stage valid/ready pipeline converting a two's-complement or unsigned multiplier result to sign-magnitude.
// Define SIGN_MAG_SAT_EN to clamp the most-negative input to the largest positive magnitude and raise sat.
module sign_magnitude_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] mult_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign,
  output logic             zero,
  output logic             sat
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_neg;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_zero;

  logic             w_s2_load;
  logic [WIDTH-1:0] w_mag;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

`ifdef SIGN_MAG_SAT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  logic w_sat;
  logic r_sat;

  // Only the most-negative value negates onto itself; clamp it instead of letting the MSB through.
  always_comb begin
    w_sat = 1'b0;
    w_mag = r_s1_neg ? (~r_s1_data + 1'b1) : r_s1_data;
    if (r_s1_neg && (r_s1_data == MOST_NEG)) begin
      w_mag = MAX_POS;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat <= 1'b0;
    end else if (w_s2_load && r_s1_valid) begin
      r_sat <= w_sat;
    end
  end

  assign sat = r_sat;
`else
  always_comb begin
    w_mag = r_s1_neg ? (~r_s1_data + 1'b1) : r_s1_data;
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_neg   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= mult_result;
        r_s1_neg  <= signed_mode & mult_result[WIDTH-1];
      end
    end
  end

  // Output registers hold their last value while stalled or when a bubble passes through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mag  <= w_mag;
        r_sign <= r_s1_neg;
        r_zero <= (w_mag == '0);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign magnitude = r_mag;
  assign sign      = r_sign;
  assign zero      = r_zero;

endmodule

// File: tb/tb_sign_magnitude_pipe.sv
// Self-checking bench for sign_magnitude_pipe: directed literal cases plus a randomized run against a queue-based model.
module tb_sign_magnitude_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         signed_mode;
  logic [W-1:0] mult_result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] magnitude;
  logic         sign;
  logic         zero;
  logic         sat;

  sign_magnitude_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .magnitude(magnitude), .sign(sign), .zero(zero), .sat(sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] mag;
    logic         sgn;
    logic         zro;
    logic         st;
  } res_t;

  res_t expq[$];
  res_t exp_item;
  res_t held;
  logic stalled = 1'b0;

  function automatic res_t model(logic [W-1:0] x, logic m);
    res_t r;
    int   v;
    v     = int'(x);
    r.sgn = 1'b0;
    r.st  = 1'b0;
    if (m && x[W-1]) begin
      v     = (1 << W) - v;
      r.sgn = 1'b1;
`ifdef SIGN_MAG_SAT_EN
      if (v == (1 << (W-1))) begin
        v    = (1 << (W-1)) - 1;
        r.st = 1'b1;
      end
`endif
    end
    r.mag = v[W-1:0];
    r.zro = (v == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest accepted input; stalled outputs must hold.
  always @(negedge clk) begin
    if (!reset) begin
      expq.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({magnitude, sign, zero, sat}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_item = expq.pop_front();
          check("out_data", 32'({magnitude, sign, zero, sat}), 32'(exp_item));
        end
      end
      if (in_valid && in_ready) expq.push_back(model(mult_result, signed_mode));
      stalled = out_valid && !out_ready;
      held    = {magnitude, sign, zero, sat};
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] m, input logic s, input logic z, input logic st);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_mag"},   32'(magnitude), 32'(m));
    check({name, "_sign"},  32'(sign), 32'(s));
    check({name, "_zero"},  32'(zero), 32'(z));
    check({name, "_sat"},   32'(sat), 32'(st));
  endtask

  task automatic single(input string name, input logic [W-1:0] x, input logic m,
                        input logic [W-1:0] em, input logic es, input logic ez, input logic est);
    in_valid = 1'b1; mult_result = x; signed_mode = m;
    cycle();
    in_valid = 1'b0;
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    cycle();
    expect_out(name, em, es, ez, est);
    cycle();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; mult_result = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({magnitude, sign, zero, sat}), 32'd0);
    reset = 1'b1;
    cycle();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_idle_valid", 32'(out_valid), 32'd0);

    single("t1", 16'hFB20, 1'b1, 16'd1248, 1'b1, 1'b0, 1'b0);

    // back-to-back pair, results on consecutive cycles
    in_valid = 1'b1; mult_result = 16'h207C; signed_mode = 1'b1;
    cycle();
    mult_result = 16'hD9B7;
    cycle();
    in_valid = 1'b0;
    expect_out("t2a", 16'd8316, 1'b0, 1'b0, 1'b0);
    cycle();
    expect_out("t2b", 16'd9801, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t2_drained", 32'(out_valid), 32'd0);

    single("t3u", 16'hD9B7, 1'b0, 16'd55735, 1'b0, 1'b0, 1'b0);
    single("t3z", 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    single("t3p", 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
`ifdef SIGN_MAG_SAT_EN
    single("t4", 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
`else
    single("t4", 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
`endif
    single("t4u", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);

    // back-pressure: fill the pipe while the output is stalled
    out_ready = 1'b0;
    in_valid = 1'b1; mult_result = 16'h0059; signed_mode = 1'b1;
    cycle();
    check("t5_ready_after_1", 32'(in_ready), 32'd1);
    mult_result = 16'hFFFF;
    cycle();
    mult_result = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      check("t5_in_ready_low", 32'(in_ready), 32'd0);
      expect_out("t5_hold", 16'd89, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("t5_in_ready_release", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    expect_out("t5_second", 16'd1, 1'b1, 1'b0, 1'b0);
    cycle();
    expect_out("t5_third", 16'd1, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t5_drained", 32'(out_valid), 32'd0);

    // reset with two items in flight
    in_valid = 1'b1; mult_result = 16'h1234; signed_mode = 1'b1;
    cycle();
    mult_result = 16'hF000;
    cycle();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid_gone", 32'(out_valid), 32'd0);
    check("t6_outputs_zero", 32'({magnitude, sign, zero, sat}), 32'd0);
    cycle();
    cycle();
    reset = 1'b1;
    check("t6_no_stale", 32'(out_valid), 32'd0);
    cycle();
    check("t6_no_stale2", 32'(out_valid), 32'd0);
    single("t6_new", 16'hFFFD, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0);
    check("t6_single", 32'(out_valid), 32'd0);

    // randomized traffic with random back-pressure, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      signed_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       mult_result = 16'h8000;
        1:       mult_result = 16'h0000;
        2:       mult_result = 16'hFFFF;
        3:       mult_result = 16'h7FFF;
        default: mult_result = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();
    check("drain_empty", 32'(expq.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
